// File: rtl/mem_wb_pkg.sv
// Shared definitions for the MEM/WB pipeline register: stall-vector bit positions and per-edge action decode.
// Pure combinational helpers; no state lives here.
package mem_wb_pkg;

  localparam int STALL_W   = 6;
  localparam int STALL_MEM = 3;
  localparam int STALL_WB  = 4;

  typedef enum logic [1:0] {
    ACT_HOLD   = 2'd0,
    ACT_BUBBLE = 2'd1,
    ACT_LOAD   = 2'd2
  } wb_act_e;

  // Priority: flush, then mem-stall (bubble if wb runs, hold if wb stalls), then capture.
  // A mem-side capture of an empty slot is also a bubble.
  function automatic wb_act_e wb_action(input logic [STALL_W-1:0] stall,
                                        input logic               flush,
                                        input logic               mem_valid);
    wb_act_e act;
    if (flush)
      act = ACT_BUBBLE;
    else if (stall[STALL_MEM] && !stall[STALL_WB])
      act = ACT_BUBBLE;
    else if (stall[STALL_MEM])
      act = ACT_HOLD;
    else if (!mem_valid)
      act = ACT_BUBBLE;
    else
      act = ACT_LOAD;
    return act;
  endfunction

endpackage

// File: rtl/mem_wb_sat_counter.sv
// Saturating up-counter with synchronous clear (clear beats increment).
// Latency 1 cycle; no backpressure, sticks at all-ones.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (inc && (cnt_q != {W{1'b1}}))
      cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign count = cnt_q;

endmodule

// File: rtl/mem_wb.sv
// MEM->WB pipeline register with $0 write suppression plus retire/bubble perf counters.
// Latency 1 cycle; backpressure via stall vector: mem-stall bubbles, mem+wb stall holds, flush bubbles.
module mem_wb
  import mem_wb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic               cnt_clr,
  input  logic               mem_valid,
  input  logic [DATA_W-1:0]  mem_result,
  input  logic [ADDR_W-1:0]  mem_waddr,
  input  logic               mem_we,
  input  logic               mem_whilo,
  input  logic [DATA_W-1:0]  mem_hi,
  input  logic [DATA_W-1:0]  mem_lo,
  output logic               wb_valid,
  output logic [DATA_W-1:0]  wb_result,
  output logic [ADDR_W-1:0]  wb_waddr,
  output logic               wb_we,
  output logic               wb_whilo,
  output logic [DATA_W-1:0]  wb_hi,
  output logic [DATA_W-1:0]  wb_lo,
  output logic [CNT_W-1:0]   retire_cnt,
  output logic [CNT_W-1:0]   bubble_cnt
);

  typedef struct packed {
    logic              valid;
    logic              we;
    logic              whilo;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
  } wb_t;

  wb_t     wb_q, wb_d;
  wb_act_e act;
  logic    retire_inc;
  logic    bubble_inc;

  always_comb begin
    act  = wb_action(stall, flush, mem_valid);
    wb_d = wb_q;
    case (act)
      ACT_BUBBLE: wb_d = '0;
      ACT_LOAD: begin
        wb_d.valid  = 1'b1;
        // $0 is hardwired zero: keep the address for visibility but never write it.
        wb_d.we     = mem_we && (mem_waddr != '0);
        wb_d.whilo  = mem_whilo;
        wb_d.waddr  = mem_waddr;
        wb_d.result = mem_result;
        wb_d.hi     = mem_hi;
        wb_d.lo     = mem_lo;
      end
      default: wb_d = wb_q;
    endcase
    retire_inc = (act == ACT_LOAD);
    bubble_inc = (act == ACT_BUBBLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      wb_q <= '0;
    else
      wb_q <= wb_d;
  end

  assign wb_valid  = wb_q.valid;
  assign wb_we     = wb_q.we;
  assign wb_whilo  = wb_q.whilo;
  assign wb_waddr  = wb_q.waddr;
  assign wb_result = wb_q.result;
  assign wb_hi     = wb_q.hi;
  assign wb_lo     = wb_q.lo;

  sat_counter #(.W(CNT_W)) u_retire_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (retire_inc),
    .count (retire_cnt)
  );

  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (bubble_inc),
    .count (bubble_cnt)
  );

endmodule
